axis_frame_sequencer: RTL and testbench

Parametrised AXI4-Stream frame sequencer between the DMA read channel and `Haze_Removal_Top`. It counts pixels against a run-time width/height and slices each incoming frame into `PASSES` back-to-back passes, e.g. pass 0 for ALE and pass 1 for TE/SRSC. It generates TUSER start-of-pass and TLAST end-of-pass, checks upstream TLAST placement, and absorbs downstream backpressure with a 2-entry skid buffer at full throughput.

---
 rtl/axis_frame_sequencer_if.sv | 19 +
 rtl/axis_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_axis_frame_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_sequencer_if.sv
// AXI4-Stream bundle shared by both sides of the frame sequencer.
//   tdata  : payload (RGB in [23:0], upper bits carried through untouched)
//   tvalid : source has a beat
//   tready : sink can take a beat
//   tlast  : end of packet (end of pass on the output side)
//   tuser  : start of pass (output side only)
// master drives tdata/tvalid/tlast/tuser; slave drives tready.
interface axis_frame_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_sequencer.sv
// Frame sequencer between the DMA read channel and the haze-removal core.
// Counts pixels against a run-time width/height, slices each frame into
// PASSES back-to-back passes, tags first/last pixel of every pass, checks the
// upstream TLAST placement and absorbs downstream stalls in a 2-entry skid
// buffer at full throughput.
// Ports:
//   ACLK, ARESET         : clock, asynchronous active-high reset
//   enable               : start / run gate
//   cfg_width/cfg_height : pixels per line / lines per pass, sampled at start
//   S_AXIS               : upstream stream (slave)
//   M_AXIS               : downstream stream (master), TUSER=first, TLAST=last of pass
//   pass_idx             : pass of the beat currently on M_AXIS
//   o_frame_done         : pulse on the handshake of the final beat of a frame
//   o_cfg_err            : sticky, start attempted with a zero dimension
//   o_last_err           : sticky, upstream TLAST disagreed with computed end of pass
module axis_frame_sequencer #(
  parameter int DATA_W = 32,
  parameter int COL_W  = 12,
  parameter int ROW_W  = 12,
  parameter int PASSES = 2,
  parameter int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic [COL_W-1:0]      cfg_width,
  input  logic [ROW_W-1:0]      cfg_height,
  axis_frame_sequencer_if.slave  S_AXIS,
  axis_frame_sequencer_if.master M_AXIS,
  output logic [PASS_W-1:0]     pass_idx,
  output logic                  o_frame_done,
  output logic                  o_cfg_err,
  output logic                  o_last_err
);

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              user;
    logic [PASS_W-1:0] pass;
  } beat_t;

  state_t            state;
  logic [COL_W-1:0]  w_m1;
  logic [ROW_W-1:0]  h_m1;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [PASS_W-1:0] pass;

  beat_t             head;
  beat_t             spare;
  beat_t             in_beat;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;

  logic              s_ready;
  logic              push;
  logic              pop;
  logic              col_end;
  logic              row_end;
  logic              tag_user;
  logic              tag_last;

  // Tagging of the beat being accepted this cycle
  assign col_end  = (col == w_m1);
  assign row_end  = (row == h_m1);
  assign tag_user = (col == '0) && (row == '0);
  assign tag_last = col_end && row_end;

  // A full buffer blocks upstream, so push with cnt==2 never happens
  assign s_ready = (state == RUN) && enable && (cnt != 2'd2);
  assign push    = S_AXIS.tvalid && s_ready;
  assign pop     = M_AXIS.tvalid && M_AXIS.tready;

  assign in_beat = '{data: S_AXIS.tdata, last: tag_last, user: tag_user, pass: pass};

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 2'd1;
    else if (pop && !push)
      cnt_nxt = cnt - 2'd1;
  end

  // Sequencing FSM: config latch, pixel/line/pass counters, sticky errors
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      w_m1       <= '0;
      h_m1       <= '0;
      col        <= '0;
      row        <= '0;
      pass       <= '0;
      o_cfg_err  <= 1'b0;
      o_last_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if ((cfg_width != '0) && (cfg_height != '0)) begin
              state      <= RUN;
              w_m1       <= cfg_width - 1'b1;
              h_m1       <= cfg_height - 1'b1;
              col        <= '0;
              row        <= '0;
              pass       <= '0;
              o_cfg_err  <= 1'b0;
              o_last_err <= 1'b0;
            end else begin
              o_cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            // Framing follows the counters; upstream TLAST is only checked
            if (S_AXIS.tlast != tag_last)
              o_last_err <= 1'b1;
            if (col_end) begin
              col <= '0;
              if (row_end) begin
                row <= '0;
                if (pass == LAST_PASS)
                  state <= DRAIN;
                else
                  pass <= pass + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt_nxt == 2'd0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: head drives M_AXIS directly, spare catches one stalled beat
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt   <= 2'd0;
      head  <= '0;
      spare <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (push && ((cnt == 2'd0) || ((cnt == 2'd1) && pop)))
        head <= in_beat;
      else if (pop && (cnt == 2'd2))
        head <= spare;
      if (push && !pop && (cnt == 2'd1))
        spare <= in_beat;
    end
  end

  assign S_AXIS.tready = s_ready;
  assign M_AXIS.tvalid = (cnt != 2'd0);
  assign M_AXIS.tdata  = head.data;
  assign M_AXIS.tlast  = head.last;
  assign M_AXIS.tuser  = head.user;
  assign pass_idx      = head.pass;
  assign o_frame_done  = pop && head.last && (head.pass == LAST_PASS);

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Testbench for axis_frame_sequencer (PASSES=2, DATA_W=32, 12-bit dims).
// Expected output beats are computed from the beat index alone: the k-th
// output carries the k-th input word, pass k/(W*H), TUSER when k%(W*H)==0
// and TLAST when k%(W*H)==W*H-1.
module tb_axis_frame_sequencer;
  localparam int DATA_W = 32;
  localparam int PASSES = 2;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        enable;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [0:0]  pass_idx;
  logic        o_frame_done;
  logic        o_cfg_err;
  logic        o_last_err;

  axis_frame_sequencer_if #(.DATA_W(DATA_W)) s_if ();
  axis_frame_sequencer_if #(.DATA_W(DATA_W)) m_if ();

  axis_frame_sequencer #(
    .DATA_W(DATA_W), .COL_W(12), .ROW_W(12), .PASSES(PASSES)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .S_AXIS(s_if), .M_AXIS(m_if), .pass_idx(pass_idx),
    .o_frame_done(o_frame_done), .o_cfg_err(o_cfg_err), .o_last_err(o_last_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [31:0] d; logic l; logic u; logic [0:0] p; } beat_t;
  typedef struct packed { logic [31:0] d; logic l; } src_t;

  src_t        src_q[$];
  beat_t       out_q[$];
  int          out_cyc[$];
  logic [31:0] exp_d[$];

  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, stall_viol = 0, cyc = 0;
  bit src_acc = 0, src_rand = 0, mrdy_rand = 0, mrdy_val = 1, held_vld = 0;
  beat_t held;

  function automatic beat_t cur_beat();
    return {m_if.tdata, m_if.tlast, m_if.tuser, pass_idx};
  endfunction

  function automatic beat_t model_beat(int k, int w, int h);
    beat_t m;
    int ppix;
    ppix = w * h;
    m.d = exp_d[k];
    m.u = (k % ppix) == 0;
    m.l = (k % ppix) == ppix - 1;
    m.p = 1'(k / ppix);
    return m;
  endfunction

  // Monitor: at the falling edge, record handshakes that the next rising edge completes
  always @(negedge ACLK) begin
    beat_t b;
    b = cur_beat();
    cyc++;
    if (ARESET) held_vld = 0;
    else begin
      if (held_vld && !(m_if.tvalid && b == held)) stall_viol++;
      held_vld = m_if.tvalid && !m_if.tready;
      held = b;
    end
    if (m_if.tvalid && m_if.tready) begin
      out_q.push_back(b);
      out_cyc.push_back(cyc);
    end
    src_acc = s_if.tvalid && s_if.tready;
    if (o_frame_done) done_cnt++;
  end

  // Upstream source and downstream ready, driven just after the rising edge
  always @(posedge ACLK) begin
    #1;
    if (src_acc && src_q.size() > 0) begin
      void'(src_q.pop_front());
      s_if.tvalid = 1'b0;
    end
    if (src_q.size() == 0) s_if.tvalid = 1'b0;
    else if (!s_if.tvalid) s_if.tvalid = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (s_if.tvalid) begin
      s_if.tdata = src_q[0].d;
      s_if.tlast = src_q[0].l;
    end
    m_if.tready = mrdy_rand ? 1'($urandom_range(0, 1)) : mrdy_val;
  end

  task automatic load_frame(int w, int h, int early);
    int ppix;
    ppix = w * h;
    src_q.delete(); exp_d.delete(); out_q.delete(); out_cyc.delete();
    for (int k = 0; k < PASSES * ppix; k++) begin
      src_t s;
      s.d = $urandom;
      s.l = (k % ppix) == ppix - 1;
      if (early >= 0 && k == early) s.l = 1'b1;
      if (early >= 0 && k == ppix - 1) s.l = 1'b0;
      exp_d.push_back(s.d);
      src_q.push_back(s);
    end
  endtask

  task automatic start_frame(int w, int h);
    @(posedge ACLK); #2;
    cfg_width = 12'(w); cfg_height = 12'(h); enable = 1'b1;
  endtask

  task automatic wait_out(int n, int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge ACLK); #2;
      if (out_q.size() >= n) break;
    end
    enable = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    n_checks++;
    if ({m_if.tvalid, m_if.tlast, m_if.tuser, o_frame_done, o_cfg_err, o_last_err, s_if.tready} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {m_if.tvalid, m_if.tlast, m_if.tuser, o_frame_done, o_cfg_err, o_last_err, s_if.tready});
    else n_pass++;
    n_checks++;
    if (m_if.tdata !== 32'h0) $display("FAIL reset_tdata: got %h want 0", m_if.tdata); else n_pass++;
    n_checks++;
    if (pass_idx !== 1'b0) $display("FAIL reset_pass_idx: got %0d want 0", pass_idx); else n_pass++;
    @(posedge ACLK); #2;
    ARESET = 1'b0;
  endtask

  task automatic test_nominal();
    int d0;
    load_frame(4, 2, -1);
    d0 = done_cnt;
    start_frame(4, 2);
    wait_out(16, 200);
    n_checks++;
    if (out_q.size() != 16) $display("FAIL nominal_count: got %0d want 16", out_q.size()); else n_pass++;
    for (int k = 0; k < 16 && k < out_q.size(); k++) begin
      beat_t e;
      e = model_beat(k, 4, 2);
      n_checks++;
      if (out_q[k] !== e) $display("FAIL nominal_beat %0d: got %h want %h", k, out_q[k], e); else n_pass++;
    end
    if (out_cyc.size() == 16) begin
      n_checks++;
      if (out_cyc[15] - out_cyc[0] != 15)
        $display("FAIL nominal_throughput: got span %0d want 15", out_cyc[15] - out_cyc[0]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL nominal_done: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if ({o_cfg_err, o_last_err} !== 2'b00) $display("FAIL nominal_errs: got %b want 00", {o_cfg_err, o_last_err}); else n_pass++;
  endtask

  task automatic test_random_stall();
    int w, h, n, d0;
    w = $urandom_range(3, 24);
    h = $urandom_range(2, 10);
    n = PASSES * w * h;
    load_frame(w, h, -1);
    d0 = done_cnt;
    stall_viol = 0;
    src_rand = 1; mrdy_rand = 1;
    start_frame(w, h);
    wait_out(n, n * 40);
    src_rand = 0; mrdy_rand = 0;
    n_checks++;
    if (out_q.size() != n) $display("FAIL random_count: got %0d want %0d", out_q.size(), n); else n_pass++;
    for (int k = 0; k < n && k < out_q.size(); k++) begin
      beat_t e;
      e = model_beat(k, w, h);
      n_checks++;
      if (out_q[k] !== e) $display("FAIL random_beat %0d (W=%0d H=%0d): got %h want %h", k, w, h, out_q[k], e); else n_pass++;
    end
    n_checks++;
    if (stall_viol != 0) $display("FAIL random_stall_stable: got %0d changes want 0", stall_viol); else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL random_done: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (o_last_err !== 1'b0) $display("FAIL random_last_err: got %b want 0", o_last_err); else n_pass++;
  endtask

  task automatic test_early_last();
    int d0;
    load_frame(4, 2, 5);
    d0 = done_cnt;
    start_frame(4, 2);
    wait_out(16, 200);
    n_checks++;
    if (out_q.size() != 16) $display("FAIL early_count: got %0d want 16", out_q.size()); else n_pass++;
    for (int k = 0; k < 16 && k < out_q.size(); k++) begin
      beat_t e;
      e = model_beat(k, 4, 2);
      n_checks++;
      if (out_q[k] !== e) $display("FAIL early_beat %0d: got %h want %h", k, out_q[k], e); else n_pass++;
    end
    n_checks++;
    if (o_last_err !== 1'b1) $display("FAIL early_last_err: got %b want 1", o_last_err); else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL early_done: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_cfg_err();
    int bad, d0;
    load_frame(1, 1, -1);
    d0 = done_cnt;
    start_frame(0, 2);
    bad = 0;
    repeat (4) begin
      @(negedge ACLK);
      if (s_if.tready || m_if.tvalid) bad++;
    end
    n_checks++;
    if (o_cfg_err !== 1'b1) $display("FAIL cfg_err_set: got %b want 1", o_cfg_err); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL cfg_err_idle: got %0d active cycles want 0", bad); else n_pass++;
    n_checks++;
    if (o_last_err !== 1'b1) $display("FAIL cfg_last_err_sticky: got %b want 1", o_last_err); else n_pass++;
    @(posedge ACLK); #2;
    cfg_width = 12'd1; cfg_height = 12'd1;
    wait_out(2, 50);
    n_checks++;
    if (out_q.size() != 2) $display("FAIL w1h1_count: got %0d want 2", out_q.size()); else n_pass++;
    for (int k = 0; k < 2 && k < out_q.size(); k++) begin
      beat_t e;
      e = model_beat(k, 1, 1);
      n_checks++;
      if (out_q[k] !== e) $display("FAIL w1h1_beat %0d: got %h want %h", k, out_q[k], e); else n_pass++;
    end
    n_checks++;
    if ({o_cfg_err, o_last_err} !== 2'b00) $display("FAIL w1h1_errs_cleared: got %b want 00", {o_cfg_err, o_last_err}); else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL w1h1_done: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_enable_gap();
    int bad, d0;
    load_frame(8, 3, -1);
    d0 = done_cnt;
    start_frame(8, 3);
    for (int i = 0; i < 200; i++) begin
      @(posedge ACLK); #2;
      if (out_q.size() >= 10) break;
    end
    enable = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (s_if.tready) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL gap_tready: got %0d ready cycles want 0", bad); else n_pass++;
    n_checks++;
    if (m_if.tvalid !== 1'b0) $display("FAIL gap_drained: got tvalid %b want 0", m_if.tvalid); else n_pass++;
    @(posedge ACLK); #2;
    enable = 1'b1;
    wait_out(48, 300);
    n_checks++;
    if (out_q.size() != 48) $display("FAIL gap_count: got %0d want 48", out_q.size()); else n_pass++;
    for (int k = 0; k < 48 && k < out_q.size(); k++) begin
      beat_t e;
      e = model_beat(k, 8, 3);
      n_checks++;
      if (out_q[k] !== e) $display("FAIL gap_beat %0d: got %h want %h", k, out_q[k], e); else n_pass++;
    end
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL gap_done: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int d0;
    load_frame(4, 2, -1);
    d0 = done_cnt;
    start_frame(4, 2);
    for (int i = 0; i < 100; i++) begin
      @(posedge ACLK); #2;
      if (out_q.size() >= 3) break;
    end
    ARESET = 1'b1;
    enable = 1'b0;
    src_q.delete();
    s_if.tvalid = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if ({m_if.tvalid, m_if.tlast, m_if.tuser, o_frame_done, o_cfg_err, o_last_err, s_if.tready} !== 7'b0)
      $display("FAIL midreset_ctrl: got %b want 0000000", {m_if.tvalid, m_if.tlast, m_if.tuser, o_frame_done, o_cfg_err, o_last_err, s_if.tready});
    else n_pass++;
    n_checks++;
    if ({m_if.tdata, pass_idx} !== 33'h0) $display("FAIL midreset_data: got %h want 0", {m_if.tdata, pass_idx}); else n_pass++;
    repeat (3) @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    n_checks++;
    if (done_cnt != d0) $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
    load_frame(2, 2, -1);
    start_frame(2, 2);
    wait_out(8, 100);
    n_checks++;
    if (out_q.size() != 8) $display("FAIL fresh_count: got %0d want 8", out_q.size()); else n_pass++;
    for (int k = 0; k < 8 && k < out_q.size(); k++) begin
      beat_t e;
      e = model_beat(k, 2, 2);
      n_checks++;
      if (out_q[k] !== e) $display("FAIL fresh_beat %0d: got %h want %h", k, out_q[k], e); else n_pass++;
    end
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL fresh_done: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  initial begin
    ARESET = 1'b1;
    enable = 1'b0;
    cfg_width = 12'd0;
    cfg_height = 12'd0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tlast = 1'b0;
    s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    test_reset();
    test_nominal();
    test_random_stall();
    test_early_last();
    test_cfg_err();
    test_enable_gap();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
